// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle FSM controller (FETCH/DECODE/EXEC/MUL_WAIT/MEM/WB)
// Ports: clk, rst_n (async active-low); opcode/funct/instr_valid/zero/mem_ready in;
//   instr_ready, ir_write, pc_write, pc_src, RegDst, JumpAndLink, MemRead, MemWrite,
//   MemtoReg, ALUOp, ALUSrc, RegWrite, MfhiLo_, hilo_write, illegal out.
// Optional macro HILO_MOVE_EN enables mfhi/mflo on opcode 0xE.
// Outputs are decoded from the registered state (plus zero/mem_ready/instr_valid where
// the cycle-level timing needs them), so reset clears them without a clock edge.
module multicycle_control_unit #(
  parameter int OPCODE_W   = 4,
  parameter int ALUOP_W    = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                RegDst,
  output logic                JumpAndLink,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                MfhiLo_,
  output logic                hilo_write,
  output logic                illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MUL_WAIT, MEM, WB} state_t;
  state_t state;
  logic [OPCODE_W-1:0] op;
  logic [2:0] fn;
  logic [7:0] cnt;
  logic [3:0] o, alu;
  logic ov, r_type, is_shift, is_hilo, is_mfhi, is_mul, is_lw, is_sw, is_beq, is_bne;
  logic is_br, is_jal, is_jr, is_jmp, bad, taken;
  assign o = op[3:0];
  assign ov = op > OPCODE_W'(14);
  assign r_type = o == 4'h0;
  assign is_shift = o == 4'hD;
`ifdef HILO_MOVE_EN
  assign is_hilo = o == 4'hE && fn < 3'd2;
`else
  assign is_hilo = 1'b0;
`endif
  assign is_mfhi = is_hilo && fn == 3'd0;
  assign is_mul = (r_type && fn == 3'd7) || o == 4'h4;
  assign is_lw = o == 4'h6;
  assign is_sw = o == 4'h7;
  assign is_beq = o == 4'h8;
  assign is_bne = o == 4'h9;
  assign is_br = is_beq || is_bne;
  assign is_jal = o == 4'hB;
  assign is_jr = o == 4'hC;
  assign is_jmp = o == 4'hA || is_jal || is_jr;
  // ov covers 0xF and every wider opcode; the decode flags are only trusted when !bad
  assign bad = ov || (is_shift && fn > 3'd2) || (o == 4'hE && !is_hilo);
  assign taken = is_beq ? zero : is_bne && !zero;
  always_comb begin
    alu = 4'h0;
    case (o)
      4'h0: alu = fn == 3'd0 ? 4'h2 : fn == 3'd1 ? 4'h6 : fn == 3'd2 ? 4'h0 : fn == 3'd3 ? 4'h1 :
                  fn == 3'd4 ? 4'h9 : fn == 3'd5 ? 4'hA : fn == 3'd6 ? 4'h7 : 4'h8;
      4'h1, 4'h6, 4'h7: alu = 4'h2;
      4'h3: alu = 4'h1;
      4'h4: alu = 4'h8;
      4'h5: alu = 4'h7;
      4'h8, 4'h9: alu = 4'h6;
      4'hD: alu = fn == 3'd0 ? 4'hC : fn == 3'd1 ? 4'hD : 4'hE;
      default: alu = 4'h0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt <= 8'd0;
      op <= '0;
      fn <= 3'd0;
    end else begin
      if (ir_write) begin
        op <= opcode;
        fn <= funct;
      end
      case (state)
        FETCH: state <= instr_valid ? DECODE : FETCH;
        DECODE: state <= (bad || is_jmp) ? FETCH : EXEC;
        EXEC: begin
          state <= is_mul ? MUL_WAIT : (is_lw || is_sw) ? MEM : is_br ? FETCH : WB;
          if (is_mul) cnt <= 8'(MUL_CYCLES - 1);
        end
        MUL_WAIT: begin
          state <= cnt == 8'd0 ? WB : MUL_WAIT;
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        MEM: state <= mem_ready ? (is_lw ? WB : FETCH) : MEM;
        WB: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end
  always_comb begin
    instr_ready = state == FETCH;
    ir_write = state == FETCH && instr_valid && rst_n;
    pc_write = ir_write;
    pc_src = 2'd0;
    RegDst = 1'b0;
    JumpAndLink = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUOp = '0;
    ALUSrc = 1'b0;
    RegWrite = 1'b0;
    MfhiLo_ = 1'b0;
    hilo_write = 1'b0;
    illegal = 1'b0;
    case (state)
      DECODE: begin
        illegal = bad;
        pc_write = !bad && is_jmp;
        pc_src = (!bad && is_jmp) ? (is_jr ? 2'd3 : 2'd2) : 2'd0;
        JumpAndLink = !bad && is_jal;
        RegWrite = !bad && is_jal;
      end
      EXEC: begin
        ALUOp = ALUOP_W'(alu);
        ALUSrc = o >= 4'h1 && o <= 4'h7;
        pc_write = taken;
        pc_src = taken ? 2'd1 : 2'd0;
        MfhiLo_ = is_mfhi;
      end
      MUL_WAIT: begin
        ALUOp = ALUOP_W'(4'h8);
        hilo_write = cnt == 8'd0;
      end
      MEM: begin
        ALUOp = ALUOP_W'(4'h2);
        MemRead = is_lw;
        MemWrite = is_sw;
      end
      WB: begin
        RegWrite = 1'b1;
        RegDst = r_type || is_shift || is_hilo;
        MemtoReg = is_lw;
        MfhiLo_ = is_mfhi;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized trace-based self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
  localparam int MC = 4;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [2:0] funct = 3'd0;
  logic instr_ready, ir_write, pc_write, RegDst, JumpAndLink, MemRead, MemWrite, MemtoReg;
  logic ALUSrc, RegWrite, MfhiLo_, hilo_write, illegal;
  logic [1:0] pc_src;
  logic [3:0] ALUOp;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic ready, irw, pcw;
    logic [1:0] pcs;
    logic rd, jal, mrd, mwr, m2r;
    logic [3:0] alu;
    logic src, rw, mhl, hw, ill;
  } out_t;
  typedef struct {
    logic iv;
    logic [3:0] opc;
    logic [2:0] fn;
    logic mrdy;
    out_t e;
  } cyc_t;
  out_t obs;
  always #5 clk = ~clk;
  assign obs = {instr_ready, ir_write, pc_write, pc_src, RegDst, JumpAndLink, MemRead, MemWrite,
                MemtoReg, ALUOp, ALUSrc, RegWrite, MfhiLo_, hilo_write, illegal};
  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(4), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .RegDst(RegDst), .JumpAndLink(JumpAndLink),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MfhiLo_(MfhiLo_), .hilo_write(hilo_write),
    .illegal(illegal));
  function automatic logic [3:0] ref_alu(input logic [3:0] o, input logic [2:0] f);
    logic [3:0] rt [8] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h9, 4'hA, 4'h7, 4'h8};
    logic [3:0] st [3] = '{4'hC, 4'hD, 4'hE};
    if (o == 4'h0) return rt[f];
    if (o == 4'hD) return f < 3 ? st[f] : 4'h0;
    case (o)
      4'h1, 4'h6, 4'h7: return 4'h2;
      4'h2: return 4'h0;
      4'h3: return 4'h1;
      4'h4: return 4'h8;
      4'h5: return 4'h7;
      4'h8, 4'h9: return 4'h6;
      default: return 4'h0;
    endcase
  endfunction
  function automatic cyc_t mk(input logic iv, input logic [3:0] o, input logic [2:0] f,
                              input logic m, input out_t e);
    cyc_t c;
    c.iv = iv; c.opc = o; c.fn = f; c.mrdy = m; c.e = e;
    return c;
  endfunction
  function automatic out_t idle_out();
    out_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction
  task automatic run_instr(input logic [3:0] o, input logic [2:0] f, input logic z, input int w,
                           input string nm);
    cyc_t q[$];
    out_t e;
    logic hilo, ill, mul, lw, sw, mfhi, tk;
    hilo = 1'b0;
`ifdef HILO_MOVE_EN
    hilo = o == 4'hE && f < 3'd2;
`endif
    mfhi = hilo && f == 3'd0;
    ill = o == 4'hF || (o == 4'hD && f > 3'd2) || (o == 4'hE && !hilo);
    mul = (o == 4'h0 && f == 3'd7) || o == 4'h4;
    lw = o == 4'h6;
    sw = o == 4'h7;
    e = idle_out(); e.irw = 1; e.pcw = 1;
    q.push_back(mk(1'b1, o, f, 1'($urandom), e));
    e = '0;
    if (ill) e.ill = 1;
    if (!ill && o inside {4'hA, 4'hB, 4'hC}) begin
      e.pcw = 1; e.pcs = o == 4'hC ? 2'd3 : 2'd2; e.jal = o == 4'hB; e.rw = o == 4'hB;
    end
    q.push_back(mk(1'b0, 4'($urandom), 3'($urandom), 1'($urandom), e));
    if (!ill && !(o inside {4'hA, 4'hB, 4'hC})) begin
      e = '0;
      e.alu = ref_alu(o, f);
      e.src = o >= 4'h1 && o <= 4'h7;
      e.mhl = mfhi;
      tk = (o == 4'h8 && z) || (o == 4'h9 && !z);
      e.pcw = tk; e.pcs = tk ? 2'd1 : 2'd0;
      q.push_back(mk(1'b0, 4'($urandom), 3'($urandom), 1'($urandom), e));
      if (mul)
        for (int k = 0; k < MC; k++) begin
          e = '0; e.alu = 4'h8; e.hw = k == MC - 1;
          q.push_back(mk(1'b0, 4'($urandom), 3'($urandom), 1'($urandom), e));
        end
      if (lw || sw)
        for (int k = 0; k <= w; k++) begin
          e = '0; e.alu = 4'h2; e.mrd = lw; e.mwr = sw;
          q.push_back(mk(1'b0, 4'($urandom), 3'($urandom), k == w, e));
        end
      if (!(o inside {4'h7, 4'h8, 4'h9})) begin
        e = '0; e.rw = 1; e.rd = o == 4'h0 || o == 4'hD || o == 4'hE; e.m2r = lw; e.mhl = mfhi;
        q.push_back(mk(1'b0, 4'($urandom), 3'($urandom), 1'($urandom), e));
      end
    end
    q.push_back(mk(1'b0, 4'($urandom), 3'($urandom), 1'($urandom), idle_out()));
    foreach (q[i]) begin
      instr_valid = q[i].iv; opcode = q[i].opc; funct = q[i].fn; mem_ready = q[i].mrdy; zero = z;
      @(negedge clk);
      checks++;
      if (obs !== q[i].e) begin
        errors++;
        $display("FAIL %s op=%h fn=%0d cyc%0d got %h exp %h", nm, o, f, i, obs, q[i].e);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset();
    instr_valid = 1; opcode = 4'h1;
    #3;
    checks++;
    if (obs !== idle_out()) begin errors++; $display("FAIL reset got %h exp %h", obs, idle_out()); end
    instr_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_directed();
    run_instr(4'h0, 3'd0, 1'b0, 0, "add");
    run_instr(4'h8, 3'd0, 1'b1, 0, "beq_z1");
    run_instr(4'h8, 3'd0, 1'b0, 0, "beq_z0");
    run_instr(4'h9, 3'd0, 1'b1, 0, "bne_z1");
    run_instr(4'h9, 3'd0, 1'b0, 0, "bne_z0");
    run_instr(4'h6, 3'd0, 1'b0, 3, "lw_wait3");
    run_instr(4'h7, 3'd0, 1'b0, 0, "sw_nowait");
    run_instr(4'h4, 3'd0, 1'b0, 0, "muli");
    run_instr(4'h0, 3'd7, 1'b0, 0, "mul");
    run_instr(4'hF, 3'd0, 1'b0, 0, "opF");
    run_instr(4'hD, 3'd5, 1'b0, 0, "shift_f5");
    run_instr(4'hD, 3'd2, 1'b0, 0, "sra");
    run_instr(4'hE, 3'd0, 1'b0, 0, "opE_f0");
    run_instr(4'hE, 3'd1, 1'b0, 0, "opE_f1");
    run_instr(4'hA, 3'd0, 1'b0, 0, "j");
    run_instr(4'hB, 3'd0, 1'b0, 0, "jal");
    run_instr(4'hC, 3'd0, 1'b0, 0, "jr");
  endtask
  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      instr_valid = 0; opcode = 4'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== idle_out()) begin errors++; $display("FAIL idle got %h exp %h", obs, idle_out()); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid();
    instr_valid = 1; opcode = 4'h7; funct = 3'd0; mem_ready = 0;
    @(posedge clk); #1;
    instr_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b1) begin errors++; $display("FAIL sw_mem_before_reset MemWrite got %b exp 1", MemWrite); end
    instr_valid = 1; rst_n = 0;
    #1;
    checks++;
    if (obs !== idle_out()) begin errors++; $display("FAIL reset_mid_async got %h exp %h", obs, idle_out()); end
    mem_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (obs !== idle_out()) begin errors++; $display("FAIL reset_mid_held got %h exp %h", obs, idle_out()); end
    instr_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    run_instr(4'h2, 3'd3, 1'b0, 0, "after_reset_andi");
  endtask
  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_instr(4'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");
      if ($urandom_range(0, 3) == 0) test_idle();
    end
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) run_instr(4'($urandom_range(0, 13)), 3'($urandom_range(0, 6)), 1'b1, 0, "b2b");
  endtask
  initial begin
    test_reset();
    test_idle();
    test_directed();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit
Interface
REQ-001 OPCODE_W, 4, opcode width; ISA encodings are zero-extended to this width.
REQ-002 ALUOP_W, 4, ALU operation code width; ALU codes are zero-extended to this width.
REQ-003 MUL_CYCLES, 4, cycles spent in MUL_WAIT for mul/muli; legal range 1..255.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 opcode  in  OPCODE_W  instruction opcode field; sampled only when ir_write is high.
REQ-007 funct  in  3  instruction function field; sampled only when ir_write is high.
REQ-008 instr_valid  in  1  fetch unit holds a valid instruction.
REQ-009 instr_ready  out  1  controller accepts an instruction this cycle.
REQ-010 zero  in  1  ALU zero flag; valid in EXEC.
REQ-011 mem_ready  in  1  data memory completes the current access this cycle.
REQ-012 ir_write  out  1  latch opcode/funct into the internal instruction register.
REQ-013 pc_write  out  1  PC update strobe.
REQ-014 pc_src  out  2  next-PC select: 0 PC+1, 1 branch target, 2 jump target, 3 register (jr).
REQ-015 RegDst  out  1  destination register is rd.
REQ-016 JumpAndLink  out  1  write the link address to the link register.
REQ-017 MemRead  out  1  data memory read request.
REQ-018 MemWrite  out  1  data memory write request.
REQ-019 MemtoReg  out  1  write-back data comes from memory.
REQ-020 ALUOp  out  ALUOP_W  ALU operation code.
REQ-021 ALUSrc  out  1  ALU operand B is the immediate.
REQ-022 RegWrite  out  1  register file write strobe.
REQ-023 MfhiLo_  out  1  write-back source select: 1 HI, 0 LO.
REQ-024 hilo_write  out  1  latch the multiplier result into HI/LO.
REQ-025 illegal  out  1  one-cycle pulse on an undefined opcode/funct.
Function
REQ-026 Decode table: op0 R-type (funct 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 mul); op1 addi; op2 andi; op3 ori; op4 muli; op5 slti; op6 lw; op7 sw; op8 beq; op9 bne; opA j; opB jal; opC jr; opD shift (funct 0 sll, 1 srl, 2 sra; funct 3..7 illegal); opE see REQ-040; opF and all higher opcodes illegal.
REQ-027 ALUOp codes: and 0, or 1, add/addi/lw/sw 2, sub/beq/bne 6, slt/slti 7, mul/muli 8, xor 9, nor A, sll C, srl D, sra E.
REQ-028 States: FETCH, DECODE, EXEC, MUL_WAIT, MEM, WB; one-hot or binary encoding is implementation choice.
REQ-029 FETCH: instr_ready=1; when instr_valid=1, assert ir_write=1, pc_write=1, pc_src=0 for that cycle and go to DECODE; otherwise remain in FETCH.
REQ-030 DECODE: an illegal instruction pulses illegal for one cycle and returns to FETCH; j, jal, jr assert pc_write with pc_src 2/2/3 (jal also asserts JumpAndLink and RegWrite) and return to FETCH; every other instruction goes to EXEC.
REQ-031 EXEC: ALUOp and ALUSrc are driven per REQ-026/027 (ALUSrc=1 for I-type, lw, sw); beq/bne assert pc_write=1, pc_src=1 exactly when zero=1 (beq) or zero=0 (bne), then return to FETCH.
REQ-032 EXEC next state: mul/muli -> MUL_WAIT with counter loaded to MUL_CYCLES-1; lw/sw -> MEM; all other instructions -> WB.
REQ-033 MUL_WAIT: ALUOp=8 is held and the counter decrements each cycle; at count 0, assert hilo_write=1 for one cycle and go to WB.
REQ-034 MEM: MemRead (lw) or MemWrite (sw) and ALUOp=2 are held until mem_ready=1; in the mem_ready cycle, lw goes to WB and sw goes to FETCH.
REQ-035 WB: RegWrite=1 for exactly one cycle; RegDst=1 for R-type/shift/mfhi/mflo; MemtoReg=1 for lw; then go to FETCH.
REQ-036 Outputs not named for a state are 0 in that state; the instruction register is updated only by ir_write.
REQ-037 Latency from instr_valid acceptance to return to FETCH: ALU/shift 4 cycles, branch 3, jump 2, lw 5 + memory wait cycles, sw 4 + memory wait cycles, mul 4+MUL_CYCLES.
Reset
REQ-038 rst_n=0 forces state FETCH, counter 0, instruction register 0, and all outputs 0 except instr_ready=1, without waiting for a clock edge.
REQ-039 Reset asserted mid-instruction aborts the instruction: no RegWrite, MemWrite, hilo_write, or pc_write occurs after reset asserts.
Configuration
REQ-040 HILO_MOVE_EN defined: opE funct 0 = mfhi (MfhiLo_=1) and funct 1 = mflo (MfhiLo_=0) pass through EXEC to WB with RegWrite=1 and RegDst=1; opE funct 2..7 are illegal.
REQ-041 HILO_MOVE_EN undefined: all opE encodings are illegal (REQ-030), and MfhiLo_ is held at 0.
Verification
REQ-042 add (op0 funct0) accepted at cycle 0 -> ALUOp=2 in cycle 2, RegWrite=1 and RegDst=1 in cycle 3, instr_ready=1 in cycle 4.
REQ-043 beq with zero=1 -> pc_write=1, pc_src=1 in EXEC; bne with zero=1 -> no pc_write in EXEC.
REQ-044 lw with mem_ready low for 3 cycles -> MemRead held 4 cycles, then WB with MemtoReg=1 and RegWrite=1.
REQ-045 muli with MUL_CYCLES=4 -> 4 MUL_WAIT cycles, hilo_write pulses in the last one, RegWrite in the following cycle.
REQ-046 opF, op0xD funct 5, and opE without HILO_MOVE_EN -> illegal pulses once, no write strobes; rst_n dropped during MEM of sw -> MemWrite falls immediately, state returns to FETCH.
